arm_control_unit: RTL and testbench
===================================

# arm_control_unit

Main control unit for the single-cycle ARM `Data_Path`. It decodes the fetched instruction into every datapath select and write-enable, and evaluates the condition field against a registered NZCV flag file. It sequences a boot cycle after reset and stalls the processor on a memory ready/valid handshake, with a bounded wait and abort. It drives the new `PCWrite` enable on the PC register, which the datapath revision adds alongside this block.

## Interface
- `MAX_WAIT`, default 15: maximum consecutive stall cycles before a memory access is aborted.
- `WAIT_W`, default 4: width of the wait counter; ≥ clog2(MAX_WAIT+1).

Ports:
- `CLK` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `Instr` in 32: current instruction.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU.
- `MemReady` in 1: data memory completes the access this cycle.
- `RegSrc` out 2; `ImmSrc` out 2; `ALUSrc` out 1; `ALUControl` out 2; `MemtoReg` out 1; `MOVInstr` out 1; `link` out 1: datapath selects.
- `RegWrite`, `MemWrite`, `PCSrc`, `PCWrite` out 1 each: commit controls.
- `MemReq` out 1: a load/store is in progress.
- `Undef` out 1: one-cycle pulse on an undefined opcode.
- `MemErr` out 1: one-cycle pulse on a wait timeout.
- `Flags` out 4: registered NZCV.

## Operation
- Fields: Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12].
- ALUControl encoding: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- Data-processing (Op 00):
  - RegSrc 00, ImmSrc 00, ALUSrc=Funct[5], RegWrite 1.
  - cmd=Funct[4:1]:
    - 0100 ADD→00
    - 0010 SUB→01
    - 0000 AND→10
    - 1100 ORR→11
    - 1101 MOV→00 with MOVInstr 1
    - 1010 CMP→01 with RegWrite 0
    - Any other cmd: Undef, no writes.
  - S=Funct[0]. When S is set, N and Z update. C and V update only for ADD/SUB/CMP.
- Memory (Op 01):
  - Common: ImmSrc 01, ALUSrc 1, ALUControl 00.
  - LDR (Funct[0]=1): RegSrc 00, MemtoReg 1, RegWrite 1.
  - STR: RegSrc 10, MemWrite 1, RegWrite 0.
- Branch (Op 10):
  - RegSrc 01, ImmSrc 10, ALUSrc 1, ALUControl 00, PCSrc 1.
  - BL (Instr[24]=1): RegWrite 1 and link 1.
- Op 11: Undef pulse; behaves as a NOP (all writes 0, PC advances).
- PCSrc also asserts when RegWrite is set and Rd=15.
- Condition check (CondEx) uses the registered Flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 0.
- When CondEx=0: RegWrite, MemWrite, PCSrc and flag update are forced to 0; MemReq is 0; PCWrite is 1.

## Timing
- FSM states: BOOT, RUN, WAIT.
  - Reset low → BOOT at the next edge. Flags=0000, counter=0.
  - BOOT: all commit outputs 0, PCWrite 0, MemReq 0. Always moves to RUN on the next edge.
  - RUN, non-memory instruction: commits in the same cycle with PCWrite 1.
  - RUN, executing LDR/STR: MemReq 1.
    - MemReady=1: commit this cycle, PCWrite 1.
    - MemReady=0: RegWrite 0, PCWrite 0, MemWrite held at its decoded value; go to WAIT with counter=1.
  - WAIT: MemReq 1.
    - MemReady=1: commit, PCWrite 1, go to RUN.
    - MemReady=0 and counter=MAX_WAIT: MemErr pulse; squash (RegWrite 0, MemWrite 0); PCWrite 1; go to RUN.
    - Otherwise: counter increments.
- Flags load on the commit-cycle edge only. A flag write never affects CondEx of the same instruction.
- A reset assertion during WAIT abandons the access: no commit, no MemErr.
- MemReady is ignored whenever MemReq=0.
- Undef and MemErr are Mealy pulses, high for exactly one cycle each.

## Structure
- Package `arm_ctrl_pkg` holds:
  - Op codes (DP/MEM/BR).
  - Cond encodings.
  - DP cmd encodings.
  - ALUControl values.
  - FSM state enum.
- Sub-module `cond_logic`: combinational Cond×Flags→CondEx, plus the registered Flags with per-field write enables (NZ, CV).
- The top level contains the decoder, the FSM and the wait counter.

## Test plan
- Reset low for 2 cycles, then release → the first cycle is BOOT with PCWrite 0 and RegWrite 0. From the second cycle on, RUN with PCWrite 1 and Flags=0000.
- SUBS R1,R1,#1 (0xE2511001) with ALUFlags=0100 → RegWrite 1, ALUControl 01, ALUSrc 1, and Flags=0100 after the edge. The following BNE (0x1AFFFFFD) → PCSrc 0, RegWrite 0.
- CMP then BEQ with ALUFlags Z=1 → the branch commits with PCSrc 1. BL (0xEB000004) → RegWrite 1, link 1, ImmSrc 10.
- LDR (0xE5912000) with MemReady low for 3 cycles → PCWrite 0 and RegWrite 0 for 3 cycles. On the 4th cycle: RegWrite 1, MemtoReg 1, PCWrite 1.
- STR with MemReady held low and MAX_WAIT=15 → MemWrite stays 1 during the stall. After 15 cycles in WAIT: MemErr pulses, MemWrite 0, PCWrite 1.
- Instr 0xEC000000 (Op 11) → Undef pulses for 1 cycle, all writes 0, PCWrite 1, Flags unchanged.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM single-cycle control unit: opcodes, condition
// codes, data-processing commands, ALU selects, FSM states and decoded controls.
package arm_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       mem_to_reg;
    logic       mov;
    logic       link;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       is_mem;
    logic       undef;
    logic       upd_nz;
    logic       upd_cv;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/arm_control_unit_if.sv
// Data-memory handshake between the control unit (master) and data memory (slave).
interface arm_control_unit_if;
  logic MemReq;
  logic MemReady;
  logic MemWrite;
  logic MemErr;

  modport master (output MemReq, output MemWrite, output MemErr, input MemReady);
  modport slave  (input MemReq, input MemWrite, input MemErr, output MemReady);
endinterface

// File: rtl/arm_control_unit_cond_logic.sv
// Condition evaluation against the registered NZCV flags; NZ and CV are
// written independently so logical ops leave carry/overflow untouched.
module cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic       nz_we,
  input  logic       cv_we,
  output logic [3:0] Flags,
  output logic       cond_ex
);

  logic [1:0] nz_r;
  logic [1:0] cv_r;
  logic       n_s, z_s, c_s, v_s;

  assign {n_s, z_s} = nz_r;
  assign {c_s, v_s} = cv_r;
  assign Flags      = {nz_r, cv_r};

  // N/Z flag bank
  always_ff @(posedge CLK) begin
    if (!reset) begin
      nz_r <= 2'b00;
    end else if (nz_we) begin
      nz_r <= ALUFlags[3:2];
    end
  end

  // C/V flag bank
  always_ff @(posedge CLK) begin
    if (!reset) begin
      cv_r <= 2'b00;
    end else if (cv_we) begin
      cv_r <= ALUFlags[1:0];
    end
  end

  // condition field against the flags as they stood before this instruction
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: cond_ex = z_s;
      COND_NE: cond_ex = ~z_s;
      COND_CS: cond_ex = c_s;
      COND_CC: cond_ex = ~c_s;
      COND_MI: cond_ex = n_s;
      COND_PL: cond_ex = ~n_s;
      COND_VS: cond_ex = v_s;
      COND_VC: cond_ex = ~v_s;
      COND_HI: cond_ex = c_s & ~z_s;
      COND_LS: cond_ex = ~c_s | z_s;
      COND_GE: cond_ex = (n_s == v_s);
      COND_LT: cond_ex = (n_s != v_s);
      COND_GT: cond_ex = ~z_s & (n_s == v_s);
      COND_LE: cond_ex = z_s | (n_s != v_s);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_control_unit.sv
// Main control unit: instruction decode, boot/run/wait sequencing with a
// bounded memory stall, and commit gating by the condition field.
module arm_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [31:0]         Instr,
  input  logic [3:0]          ALUFlags,
  arm_control_unit_if.master  mem_bus,
  output logic [1:0]          RegSrc,
  output logic [1:0]          ImmSrc,
  output logic                ALUSrc,
  output logic [1:0]          ALUControl,
  output logic                MemtoReg,
  output logic                MOVInstr,
  output logic                link,
  output logic                RegWrite,
  output logic                PCSrc,
  output logic                PCWrite,
  output logic                Undef,
  output logic [3:0]          Flags
);

  op_e         op_s;
  logic [5:0]  funct_s;
  logic [3:0]  rd_s;
  ctrl_t       ctrl_s;
  logic        cond_ex_s;
  logic        mem_go_s;
  logic        timeout_s;
  logic        exec_s;
  logic        unused_instr_s;

  state_e      state_r, state_next_s;
  logic [WAIT_W-1:0] cnt_r, cnt_next_s;

  logic        commit_s, pc_write_s, mem_req_s, hold_s, mem_err_s, undef_s;

  assign op_s           = op_e'(Instr[27:26]);
  assign funct_s        = Instr[25:20];
  assign rd_s           = Instr[15:12];
  assign unused_instr_s = ^{Instr[19:16], Instr[11:0]};

  // instruction decode into datapath selects and uncommitted write intents
  always_comb begin
    ctrl_s = CTRL_NOP;
    case (op_s)
      OP_DP: begin
        ctrl_s.alu_src   = funct_s[5];
        ctrl_s.reg_write = 1'b1;
        ctrl_s.upd_nz    = funct_s[0];
        case (funct_s[4:1])
          CMD_ADD: begin
            ctrl_s.alu_ctrl = ALU_ADD;
            ctrl_s.upd_cv   = funct_s[0];
          end
          CMD_SUB: begin
            ctrl_s.alu_ctrl = ALU_SUB;
            ctrl_s.upd_cv   = funct_s[0];
          end
          CMD_AND: ctrl_s.alu_ctrl = ALU_AND;
          CMD_ORR: ctrl_s.alu_ctrl = ALU_ORR;
          CMD_MOV: begin
            ctrl_s.alu_ctrl = ALU_ADD;
            ctrl_s.mov      = 1'b1;
          end
          CMD_CMP: begin
            ctrl_s.alu_ctrl  = ALU_SUB;
            ctrl_s.reg_write = 1'b0;
            ctrl_s.upd_cv    = funct_s[0];
          end
          default: begin
            ctrl_s.reg_write = 1'b0;
            ctrl_s.upd_nz    = 1'b0;
            ctrl_s.undef     = 1'b1;
          end
        endcase
      end
      OP_MEM: begin
        ctrl_s.imm_src  = 2'b01;
        ctrl_s.alu_src  = 1'b1;
        ctrl_s.alu_ctrl = ALU_ADD;
        ctrl_s.is_mem   = 1'b1;
        if (funct_s[0]) begin
          ctrl_s.mem_to_reg = 1'b1;
          ctrl_s.reg_write  = 1'b1;
        end else begin
          ctrl_s.reg_src   = 2'b10;
          ctrl_s.mem_write = 1'b1;
        end
      end
      OP_BR: begin
        ctrl_s.reg_src   = 2'b01;
        ctrl_s.imm_src   = 2'b10;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_ctrl  = ALU_ADD;
        ctrl_s.branch    = 1'b1;
        ctrl_s.link      = Instr[24];
        ctrl_s.reg_write = Instr[24];
      end
      default: ctrl_s.undef = 1'b1;
    endcase
  end

  cond_logic u_cond (
    .CLK      (CLK),
    .reset    (reset),
    .Cond     (Instr[31:28]),
    .ALUFlags (ALUFlags),
    .nz_we    (exec_s & ctrl_s.upd_nz),
    .cv_we    (exec_s & ctrl_s.upd_cv),
    .Flags    (Flags),
    .cond_ex  (cond_ex_s)
  );

  assign mem_go_s  = ctrl_s.is_mem & cond_ex_s;
  assign timeout_s = (cnt_r == WAIT_W'(MAX_WAIT));

  // state and wait-counter registers
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_r <= ST_BOOT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // next state: a stalled access waits until ready or until the budget runs out
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_BOOT: begin
        state_next_s = ST_RUN;
        cnt_next_s   = '0;
      end
      ST_RUN: begin
        if (mem_go_s && !mem_bus.MemReady) begin
          state_next_s = ST_WAIT;
          cnt_next_s   = WAIT_W'(1);
        end else begin
          state_next_s = ST_RUN;
          cnt_next_s   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_bus.MemReady || timeout_s) begin
          state_next_s = ST_RUN;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_WAIT;
          cnt_next_s   = cnt_r + WAIT_W'(1);
        end
      end
      default: begin
        state_next_s = ST_BOOT;
        cnt_next_s   = '0;
      end
    endcase
  end

  // per-state commit, PC advance and handshake strobes; reset masks everything
  always_comb begin
    commit_s   = 1'b0;
    pc_write_s = 1'b0;
    mem_req_s  = 1'b0;
    hold_s     = 1'b0;
    mem_err_s  = 1'b0;
    undef_s    = 1'b0;
    if (reset) begin
      case (state_r)
        ST_RUN: begin
          undef_s = ctrl_s.undef;
          if (mem_go_s) begin
            mem_req_s = 1'b1;
            if (mem_bus.MemReady) begin
              commit_s   = 1'b1;
              pc_write_s = 1'b1;
            end else begin
              hold_s = 1'b1;
            end
          end else begin
            commit_s   = 1'b1;
            pc_write_s = 1'b1;
          end
        end
        ST_WAIT: begin
          mem_req_s = 1'b1;
          if (mem_bus.MemReady) begin
            commit_s   = 1'b1;
            pc_write_s = 1'b1;
          end else if (timeout_s) begin
            mem_err_s  = 1'b1;
            pc_write_s = 1'b1;
          end else begin
            hold_s = 1'b1;
          end
        end
        default: begin
          commit_s = 1'b0;
        end
      endcase
    end else begin
      commit_s = 1'b0;
    end
  end

  assign exec_s           = commit_s & cond_ex_s;
  assign RegWrite         = exec_s & ctrl_s.reg_write;
  assign PCSrc            = exec_s & (ctrl_s.branch | (ctrl_s.reg_write & (rd_s == 4'hF)));
  assign PCWrite          = pc_write_s;
  assign Undef            = undef_s;
  assign mem_bus.MemWrite = (exec_s | hold_s) & ctrl_s.mem_write;
  assign mem_bus.MemReq   = mem_req_s;
  assign mem_bus.MemErr   = mem_err_s;

  assign RegSrc     = ctrl_s.reg_src;
  assign ImmSrc     = ctrl_s.imm_src;
  assign ALUSrc     = ctrl_s.alu_src;
  assign ALUControl = ctrl_s.alu_ctrl;
  assign MemtoReg   = ctrl_s.mem_to_reg;
  assign MOVInstr   = ctrl_s.mov;
  assign link       = ctrl_s.link;

endmodule

// File: tb/tb_arm_control_unit.sv
// Scoreboard bench: the driver predicts each cycle's outputs from an
// instruction-level model and queues them; a negedge monitor compares.
module tb_arm_control_unit;

  localparam int MAX_WAIT = 15;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        ALUSrc, MemtoReg, MOVInstr, link, RegWrite, PCSrc, PCWrite, Undef;
  logic [3:0]  Flags;

  arm_control_unit_if mif ();

  arm_control_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .mem_bus    (mif),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .MemtoReg   (MemtoReg),
    .MOVInstr   (MOVInstr),
    .link       (link),
    .RegWrite   (RegWrite),
    .PCSrc      (PCSrc),
    .PCWrite    (PCWrite),
    .Undef      (Undef),
    .Flags      (Flags)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] regsrc, immsrc, aluctrl;
    logic alusrc, memtoreg, mov, lnk;
    logic regwrite, memwrite, pcsrc, pcwrite, memreq, undef, memerr;
    logic [3:0] flags;
    bit chk_sel, chk_flags;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  // model state: boot cycle pending, architectural flags, stalled cycles so far
  bit         m_boot  = 1'b1;
  logic [3:0] m_flags = 4'h0;
  int         m_stall = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [3:0] af, input logic mr, input logic rs);
    exp_t e;
    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic [7:0] base;
    logic n, z, c, v, ok, rw, mw, br, ismem, ldr, dp_ok, arith;
    @(posedge CLK);
    #1;
    Instr = ins; ALUFlags = af; mif.MemReady = mr; reset = rs;
    e = '{default: '0};
    e.flags = m_flags;
    e.chk_flags = rs;
    if (!rs) begin
      m_boot = 1'b1; m_flags = 4'h0; m_stall = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      cond = ins[31:28]; op = ins[27:26]; cmd = ins[24:21]; rd = ins[15:12];
      rw = 1'b0; mw = 1'b0; br = 1'b0; ismem = 1'b0; ldr = 1'b0; dp_ok = 1'b0; arith = 1'b0;
      case (op)
        2'd0: begin
          e.alusrc = ins[25]; rw = 1'b1; dp_ok = 1'b1;
          case (cmd)
            4'd4:  begin e.aluctrl = 2'd0; arith = 1'b1; end
            4'd2:  begin e.aluctrl = 2'd1; arith = 1'b1; end
            4'd0:  e.aluctrl = 2'd2;
            4'd12: e.aluctrl = 2'd3;
            4'd13: e.mov = 1'b1;
            4'd10: begin e.aluctrl = 2'd1; arith = 1'b1; rw = 1'b0; end
            default: begin dp_ok = 1'b0; rw = 1'b0; end
          endcase
          e.undef = ~dp_ok;
        end
        2'd1: begin
          ismem = 1'b1; ldr = ins[20];
          e.immsrc = 2'd1; e.alusrc = 1'b1;
          e.regsrc = ldr ? 2'd0 : 2'd2;
          e.memtoreg = ldr; rw = ldr; mw = ~ldr;
        end
        2'd2: begin
          e.regsrc = 2'd1; e.immsrc = 2'd2; e.alusrc = 1'b1; br = 1'b1;
          e.lnk = ins[24]; rw = ins[24];
        end
        default: e.undef = 1'b1;
      endcase
      e.chk_sel = ~e.undef;
      {n, z, c, v} = m_flags;
      // odd condition codes are the negation of the even one below them
      base = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
      ok = base[cond[3:1]] ^ cond[0];
      if (ok && ismem) begin
        e.memreq = 1'b1;
        if (mr) begin
          e.regwrite = rw; e.memwrite = mw; e.pcsrc = rw && (rd == 4'hF);
          e.pcwrite = 1'b1; m_stall = 0;
        end else if (m_stall == MAX_WAIT) begin
          e.memerr = 1'b1; e.pcwrite = 1'b1; m_stall = 0;
        end else begin
          e.memwrite = mw; m_stall++;
        end
      end else begin
        e.pcwrite = 1'b1;
        if (ok) begin
          e.regwrite = rw;
          e.pcsrc = br | (rw && (rd == 4'hF));
          if (op == 2'd0 && dp_ok && ins[20]) begin
            m_flags[3:2] = af[3:2];
            if (arith) m_flags[1:0] = af[1:0];
          end
        end
      end
    end
    sb.push_back(e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cond, rd, rn;
    logic [1:0] op;
    logic [5:0] funct;
    logic [11:0] imm;
    int sel, k;
    sel = $urandom_range(0, 7);
    cond = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
    funct = 6'($urandom);
    rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    rn = 4'($urandom);
    imm = 12'($urandom);
    if (sel <= 2) begin
      op = 2'd0;
      k = $urandom_range(0, 6);
      case (k)
        0: funct[4:1] = 4'd4;
        1: funct[4:1] = 4'd2;
        2: funct[4:1] = 4'd0;
        3: funct[4:1] = 4'd12;
        4: funct[4:1] = 4'd13;
        5: funct[4:1] = 4'd10;
        default: funct[4:1] = 4'($urandom);
      endcase
    end else if (sel <= 4) begin
      op = 2'd1;
    end else if (sel <= 6) begin
      op = 2'd2;
    end else begin
      op = 2'd3;
    end
    return {cond, op, funct, rn, rd, imm};
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("RegWrite", 4'(RegWrite), 4'(me.regwrite));
        chk("MemWrite", 4'(mif.MemWrite), 4'(me.memwrite));
        chk("PCSrc", 4'(PCSrc), 4'(me.pcsrc));
        chk("PCWrite", 4'(PCWrite), 4'(me.pcwrite));
        chk("MemReq", 4'(mif.MemReq), 4'(me.memreq));
        chk("Undef", 4'(Undef), 4'(me.undef));
        chk("MemErr", 4'(mif.MemErr), 4'(me.memerr));
        if (me.chk_flags) chk("Flags", Flags, me.flags);
        if (me.chk_sel) begin
          chk("RegSrc", 4'(RegSrc), 4'(me.regsrc));
          chk("ImmSrc", 4'(ImmSrc), 4'(me.immsrc));
          chk("ALUSrc", 4'(ALUSrc), 4'(me.alusrc));
          chk("ALUControl", 4'(ALUControl), 4'(me.aluctrl));
          chk("MemtoReg", 4'(MemtoReg), 4'(me.memtoreg));
          chk("MOVInstr", 4'(MOVInstr), 4'(me.mov));
          chk("link", 4'(link), 4'(me.lnk));
        end
      end
    end
  end

  initial begin
    logic [31:0] cur;
    bit low;
    reset = 1'b0; Instr = 32'hE0800000; ALUFlags = 4'h0; mif.MemReady = 1'b0;
    cur = 32'hE0800000; low = 1'b0;

    // reset, boot, first run cycle
    step(32'hE0800000, 4'h0, 1'b0, 1'b0);
    step(32'hE0800000, 4'h0, 1'b0, 1'b0);
    step(32'hE0800000, 4'hF, 1'b1, 1'b1);
    step(32'hE0800000, 4'hF, 1'b1, 1'b1);
    // SUBS then a not-taken BNE
    step(32'hE2511001, 4'h4, 1'b1, 1'b1);
    step(32'h1AFFFFFD, 4'h0, 1'b1, 1'b1);
    // CMP, taken BEQ, BL
    step(32'hE3500000, 4'h4, 1'b0, 1'b1);
    step(32'h0A000002, 4'h0, 1'b0, 1'b1);
    step(32'hEB000004, 4'h0, 1'b0, 1'b1);
    // LDR stalled three cycles
    repeat (3) step(32'hE5912000, 4'h0, 1'b0, 1'b1);
    step(32'hE5912000, 4'h0, 1'b1, 1'b1);
    // STR times out
    repeat (MAX_WAIT + 1) step(32'hE5812000, 4'h0, 1'b0, 1'b1);
    step(32'hE0800000, 4'h0, 1'b0, 1'b1);
    // undefined opcode with flags that must not load
    step(32'hEC000000, 4'hF, 1'b1, 1'b1);
    step(32'hE0800000, 4'h0, 1'b1, 1'b1);
    // reset in the middle of a stalled load
    repeat (3) step(32'hE5912000, 4'h0, 1'b0, 1'b1);
    step(32'hE5912000, 4'h0, 1'b0, 1'b0);
    step(32'hE5912000, 4'h0, 1'b1, 1'b1);
    step(32'hE5912000, 4'h0, 1'b1, 1'b1);

    for (int i = 0; i < 900; i++) begin
      if (m_stall == 0) begin
        cur = rand_instr();
        low = ($urandom_range(0, 5) == 0);
      end
      step(cur, 4'($urandom), low ? 1'b0 : ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 149) != 0));
    end

    repeat (2) @(posedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
